multicycle_ctrl_fsm: RTL and testbench

- Main sequencing FSM for the multicycle version of the ARM core.
- Sits between the instruction decoder and the shared datapath: one ALU, one memory port, one register-file write port.
- Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the Moore-style enables and mux selects.
- Adds a second writeback cycle for long multiplies (RdLo, then RdHi) and holds on memory wait states.

---
 rtl/multicycle_ctrl_fsm_pkg.sv | 56 +++++
 rtl/multicycle_ctrl_fsm_if.sv | 38 +++
 rtl/multicycle_ctrl_fsm_outdec.sv | 89 ++++++++
 rtl/multicycle_ctrl_fsm.sv | 102 ++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle ARM control FSM: state encoding,
// datapath select codes, op classes and the packed control-output bundle.
package multicycle_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StAluWb2   = 4'd9,
        StBranch   = 4'd10
    } state_e;

    // ALU A operand select
    localparam logic [1:0] SrcARn      = 2'b00;
    localparam logic [1:0] SrcAPc      = 2'b01;
    // ALU B operand select
    localparam logic [1:0] SrcBRm      = 2'b00;
    localparam logic [1:0] SrcBImm     = 2'b01;
    localparam logic [1:0] SrcBFour    = 2'b10;
    // Result bus select
    localparam logic [1:0] ResAluOut   = 2'b00;
    localparam logic [1:0] ResReadData = 2'b01;
    localparam logic [1:0] ResAlu      = 2'b10;
    // Instruction op classes, Instr[27:26]
    localparam logic [1:0] OpDp        = 2'b00;
    localparam logic [1:0] OpMem       = 2'b01;
    localparam logic [1:0] OpBr        = 2'b10;
    localparam logic [1:0] OpMul       = 2'b11;

    typedef struct packed {
        logic       ir_write;
        logic       next_pc;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic       alu_op;
        logic [1:0] result_src;
        logic       reg_w;
        logic       write_hi;
        logic       mem_w;
        logic       branch;
        logic       instr_done;
    } ctrl_out_t;

    // A memory access completes this cycle; with waits disabled it always does.
    function automatic logic mem_done(input logic ready, input logic wait_en);
        return ready | ~wait_en;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Decoder/datapath-facing bundle of the control FSM. The master side supplies
// decoded instruction fields and memory status; the slave (the FSM) returns
// enables and mux selects.
interface multicycle_ctrl_fsm_if;

    logic [1:0] op;
    logic [5:0] funct;
    logic       cond_ex;
    logic       is_long;
    logic       no_write;
    logic       mem_ready;

    logic       ir_write;
    logic       next_pc;
    logic       adr_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_op;
    logic [1:0] result_src;
    logic       reg_w;
    logic       write_hi;
    logic       mem_w;
    logic       branch;
    logic       instr_done;

    modport master (
        output op, funct, cond_ex, is_long, no_write, mem_ready,
        input  ir_write, next_pc, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, reg_w, write_hi, mem_w, branch, instr_done
    );

    modport slave (
        input  op, funct, cond_ex, is_long, no_write, mem_ready,
        output ir_write, next_pc, adr_src, alu_src_a, alu_src_b, alu_op,
               result_src, reg_w, write_hi, mem_w, branch, instr_done
    );

endinterface

// File: rtl/multicycle_ctrl_fsm_outdec.sv
// Combinational output decoder: maps the current state (plus the few status
// inputs that gate single-cycle pulses) onto the control-output bundle.
module multicycle_ctrl_fsm_outdec
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter bit MemWaitEn = 1'b1
) (
    input  state_e    state_i,
    input  logic      mem_ready_i,
    input  logic      cond_ex_i,
    input  logic      is_long_i,
    input  logic      no_write_i,
    output ctrl_out_t out_o
);

    logic ready;

    // Per-state output decode; anything not named in a state stays 0.
    always_comb begin
        out_o = '0;
        ready = mem_done(mem_ready_i, MemWaitEn);
        unique case (state_i)
            StFetch: begin
                out_o.alu_src_a  = SrcAPc;
                out_o.alu_src_b  = SrcBFour;
                out_o.result_src = ResAlu;
                out_o.ir_write   = ready;
                out_o.next_pc    = ready;
            end
            StDecode: begin
                out_o.alu_src_a  = SrcAPc;
                out_o.alu_src_b  = SrcBFour;
                out_o.result_src = ResAlu;
                out_o.instr_done = ~cond_ex_i;
            end
            StMemAdr: begin
                out_o.alu_src_a = SrcARn;
                out_o.alu_src_b = SrcBImm;
            end
            StMemRead: begin
                out_o.adr_src    = 1'b1;
                out_o.result_src = ResAluOut;
            end
            StMemWb: begin
                out_o.result_src = ResReadData;
                out_o.reg_w      = 1'b1;
                out_o.instr_done = 1'b1;
            end
            StMemWrite: begin
                out_o.adr_src    = 1'b1;
                out_o.result_src = ResAluOut;
                // Write strobe only in the completing cycle so a stalled store
                // is committed exactly once.
                out_o.mem_w      = ready;
                out_o.instr_done = ready;
            end
            StExecR: begin
                out_o.alu_src_a = SrcARn;
                out_o.alu_src_b = SrcBRm;
                out_o.alu_op    = 1'b1;
            end
            StExecI: begin
                out_o.alu_src_a = SrcARn;
                out_o.alu_src_b = SrcBImm;
                out_o.alu_op    = 1'b1;
            end
            StAluWb: begin
                out_o.result_src = ResAluOut;
                out_o.reg_w      = ~no_write_i;
                out_o.instr_done = ~is_long_i;
            end
            StAluWb2: begin
                out_o.result_src = ResAluOut;
                out_o.reg_w      = 1'b1;
                out_o.write_hi   = 1'b1;
                out_o.instr_done = 1'b1;
            end
            StBranch: begin
                out_o.alu_src_a  = SrcARn;
                out_o.alu_src_b  = SrcBImm;
                out_o.result_src = ResAlu;
                out_o.branch     = 1'b1;
                out_o.instr_done = 1'b1;
            end
            default: out_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencing FSM of the multicycle ARM core: holds the state register
// and next-state logic, and gates the output decoder's enables during reset.
module multicycle_ctrl_fsm
    import multicycle_ctrl_fsm_pkg::*;
#(
    parameter bit MemWaitEn = 1'b1
) (
    input logic                   clk,
    input logic                   reset,
    multicycle_ctrl_fsm_if.slave  ctrl_if
);

    state_e    state_q, state_d;
    logic      ready;
    ctrl_out_t dec_out;
    ctrl_out_t ctrl_out;

    // State register; reset abandons any in-flight instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state sequencing.
    always_comb begin
        state_d = state_q;
        ready   = mem_done(ctrl_if.mem_ready, MemWaitEn);
        unique case (state_q)
            StFetch: begin
                if (ready) state_d = StDecode;
            end
            StDecode: begin
                if (!ctrl_if.cond_ex) begin
                    state_d = StFetch;
                end else begin
                    case (ctrl_if.op)
                        OpMem:   state_d = StMemAdr;
                        OpBr:    state_d = StBranch;
                        OpDp:    state_d = ctrl_if.funct[5] ? StExecI : StExecR;
                        OpMul:   state_d = StExecR;
                        default: state_d = StFetch;
                    endcase
                end
            end
            StMemAdr:   state_d = ctrl_if.funct[0] ? StMemRead : StMemWrite;
            StMemRead: begin
                if (ready) state_d = StMemWb;
            end
            StMemWb:    state_d = StFetch;
            StMemWrite: begin
                if (ready) state_d = StFetch;
            end
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = ctrl_if.is_long ? StAluWb2 : StFetch;
            StAluWb2:   state_d = StFetch;
            StBranch:   state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    multicycle_ctrl_fsm_outdec #(
        .MemWaitEn (MemWaitEn)
    ) u_outdec (
        .state_i     (state_q),
        .mem_ready_i (ctrl_if.mem_ready),
        .cond_ex_i   (ctrl_if.cond_ex),
        .is_long_i   (ctrl_if.is_long),
        .no_write_i  (ctrl_if.no_write),
        .out_o       (dec_out)
    );

    // Suppress all side-effecting enables while reset is held.
    always_comb begin
        ctrl_out = dec_out;
        if (reset) begin
            ctrl_out.ir_write   = 1'b0;
            ctrl_out.next_pc    = 1'b0;
            ctrl_out.reg_w      = 1'b0;
            ctrl_out.mem_w      = 1'b0;
            ctrl_out.branch     = 1'b0;
            ctrl_out.instr_done = 1'b0;
        end
    end

    assign ctrl_if.ir_write   = ctrl_out.ir_write;
    assign ctrl_if.next_pc    = ctrl_out.next_pc;
    assign ctrl_if.adr_src    = ctrl_out.adr_src;
    assign ctrl_if.alu_src_a  = ctrl_out.alu_src_a;
    assign ctrl_if.alu_src_b  = ctrl_out.alu_src_b;
    assign ctrl_if.alu_op     = ctrl_out.alu_op;
    assign ctrl_if.result_src = ctrl_out.result_src;
    assign ctrl_if.reg_w      = ctrl_out.reg_w;
    assign ctrl_if.write_hi   = ctrl_out.write_hi;
    assign ctrl_if.mem_w      = ctrl_out.mem_w;
    assign ctrl_if.branch     = ctrl_out.branch;
    assign ctrl_if.instr_done = ctrl_out.instr_done;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Testbench for multicycle_ctrl_fsm: directed instructions from the test plan
// followed by randomized instruction streams with random wait states. The
// expected per-cycle pulses come from instruction-level timing arithmetic.
module tb_multicycle_ctrl_fsm;

    logic clk = 1'b0;
    logic reset;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm #(
        .MemWaitEn (1'b1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .ctrl_if (bus)
    );

    // {ir_write, next_pc, reg_w, write_hi, mem_w, branch, instr_done, adr_src}
    function automatic logic [7:0] pulse_vec();
        return {bus.ir_write, bus.next_pc, bus.reg_w, bus.write_hi,
                bus.mem_w, bus.branch, bus.instr_done, bus.adr_src};
    endfunction

    // {alu_src_a, alu_src_b, result_src, alu_op}
    function automatic logic [7:0] sel_vec();
        return {1'b0, bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_op};
    endfunction

    task automatic check(input string tag, input int cyc, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    // Runs one instruction starting at a negedge with the FSM in FETCH.
    // fw = fetch wait cycles, mw = data-memory wait cycles.
    task automatic run_instr(input string tag, input logic [1:0] op, input logic [5:0] funct,
                             input logic cond, input logic lng, input logic nw,
                             input int fw, input int mw);
        int cls;   // 0 cond-fail, 1 branch, 2 data-processing, 3 load, 4 store
        int n;
        int ms;
        logic [7:0] e;
        logic [7:0] res_exp;
        logic mem_cyc;
        if (!cond)              cls = 0;
        else if (op == 2'b10)   cls = 1;
        else if (op == 2'b01)   cls = funct[0] ? 3 : 4;
        else                    cls = 2;
        ms = fw + 3;  // first memory-access cycle for loads/stores
        case (cls)
            0:       begin n = fw + 2;                 res_exp = 8'b10; end
            1:       begin n = fw + 3;                 res_exp = 8'b10; end
            2:       begin n = fw + (lng ? 5 : 4);     res_exp = 8'b00; end
            3:       begin n = fw + 5 + mw;            res_exp = 8'b01; end
            default: begin n = fw + 4 + mw;            res_exp = 8'b00; end
        endcase
        bus.op       = op;
        bus.funct    = funct;
        bus.cond_ex  = cond;
        bus.is_long  = lng;
        bus.no_write = nw;
        for (int i = 0; i < n; i++) begin
            mem_cyc = (cls == 3 || cls == 4) && i >= ms && i <= ms + mw;
            if (i < fw)        bus.mem_ready = 1'b0;
            else if (i == fw)  bus.mem_ready = 1'b1;
            else if (mem_cyc)  bus.mem_ready = (i == ms + mw);
            else               bus.mem_ready = 1'($urandom_range(0, 1));
            e    = '0;
            e[7] = (i == fw);
            e[6] = (i == fw);
            if (cls == 3)      e[5] = (i == n - 1);
            else if (cls == 2) e[5] = lng ? ((i == n - 2 && !nw) || i == n - 1)
                                          : (i == n - 1 && !nw);
            e[4] = (cls == 2) && lng && (i == n - 1);
            e[3] = (cls == 4) && (i == n - 1);
            e[2] = (cls == 1) && (i == n - 1);
            e[1] = (i == n - 1);
            e[0] = mem_cyc;
            #1;
            check(tag, i, pulse_vec(), e);
            if (i == n - 1) check({tag, "_result_src"}, i, {6'b0, bus.result_src}, res_exp);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [1:0] r_op;
        logic [5:0] r_funct;
        int         r_cls;

        reset         = 1'b1;
        bus.op        = 2'b00;
        bus.funct     = 6'b0;
        bus.cond_ex   = 1'b1;
        bus.is_long   = 1'b0;
        bus.no_write  = 1'b0;
        bus.mem_ready = 1'b1;

        // Reset: enables forced low, selects at FETCH values.
        @(negedge clk);
        #1;
        check("reset_pulses", 0, pulse_vec(), 8'b0);
        check("reset_selects", 0, sel_vec(), 8'b0_01_10_10_0);
        @(negedge clk);
        reset = 1'b0;

        // Directed test-plan instructions.
        run_instr("add_imm", 2'b00, 6'b101000, 1'b1, 1'b0, 1'b0, 0, 0);
        run_instr("cmp_reg", 2'b00, 6'b010101, 1'b1, 1'b0, 1'b1, 0, 0);
        run_instr("umull",   2'b11, 6'b001001, 1'b1, 1'b1, 1'b0, 0, 0);
        run_instr("str_w3",  2'b01, 6'b011000, 1'b1, 1'b0, 1'b0, 0, 3);
        run_instr("ldr_fw2", 2'b01, 6'b011001, 1'b1, 1'b0, 1'b0, 2, 0);
        run_instr("b_taken", 2'b10, 6'b100000, 1'b1, 1'b0, 1'b0, 0, 0);

        // Load stalled in MEMREAD, then reset mid-instruction.
        bus.op = 2'b01; bus.funct = 6'b011001; bus.cond_ex = 1'b1;
        bus.is_long = 1'b0; bus.no_write = 1'b0; bus.mem_ready = 1'b1;
        @(negedge clk);                    // now DECODE
        bus.mem_ready = 1'b0;
        @(negedge clk);                    // now MEMADR
        @(negedge clk);                    // now MEMREAD, stalled
        #1;
        check("ldr_stall_memread", 3, pulse_vec(), 8'b0000_0001);
        bus.mem_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("midreset_pulses", 0, pulse_vec(), 8'b0);
        check("midreset_selects", 0, sel_vec(), 8'b0_01_10_10_0);
        @(negedge clk);
        #1;
        check("midreset_hold", 1, pulse_vec(), 8'b0);
        reset = 1'b0;
        run_instr("b_condfail", 2'b10, 6'b100000, 1'b0, 1'b0, 1'b0, 0, 0);

        // Randomized instruction stream.
        for (int k = 0; k < 150; k++) begin
            r_cls   = $urandom_range(0, 5);
            r_funct = 6'($urandom);
            case (r_cls)
                0:       begin r_op = 2'b00; r_funct[5] = 1'b1; end
                1:       begin r_op = 2'b00; r_funct[5] = 1'b0; end
                2:       r_op = 2'b11;
                3:       begin r_op = 2'b01; r_funct[0] = 1'b1; end
                4:       begin r_op = 2'b01; r_funct[0] = 1'b0; end
                default: r_op = 2'b10;
            endcase
            run_instr("rand", r_op, r_funct, 1'($urandom_range(0, 7) != 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
